dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-requester round-robin arbiter and access sequencer in front of the byte-addressed, big-endian, 1 KiB word data memory. It accepts word load/store requests from two masters (port 0: CPU MEM stage; port 1: debug/DMA loader) and drives the memory's address, write-data and write-enable inputs. It captures the memory's negedge-registered read data and returns it with a one-cycle acknowledge. Exactly one access is in flight at a time.

## Interface
- RR_INIT, 0, requester favoured on the first simultaneous request after reset (0 or 1)
- clk  in  1  system clock; all state on posedge
- rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request; held high until the matching ack
- we0 / we1  in  1  1 = store word, 0 = load word; stable while req high
- addr0 / addr1  in  32  byte address; bits [9:0] reach memory, [31:10] ignored
- wdata0 / wdata1  in  32  store data, big-endian (bits 31:24 to lowest byte)
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  32  load result; valid in the ack cycle, held until the next ack on that port
- err0 / err1  out  1  access rejected; valid with ack
- mem_addr  out  32  to memory Addr
- mem_din  out  32  to memory Data_in
- mem_wr  out  1  to memory MemWr
- mem_dout  in  32  from memory Data_out (updated on negedge when MemWr=0)

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: mem_wr=0. If any req is high, pick the winner, latch its we/addr/wdata into mem_addr/mem_din/mem_wr, record the winner, then go to ACCESS. Otherwise stay in IDLE.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not granted last wins.
  - The last-grant pointer resets to the value that makes RR_INIT win first. It updates only when a grant is issued.
- ACCESS (exactly 1 cycle):
  - Store: mem_wr=1; memory commits all 4 bytes at the posedge ending ACCESS.
  - Load: mem_wr=0; memory updates mem_dout at the mid-cycle negedge; the arbiter samples mem_dout into the winner's rdata at the posedge ending ACCESS.
  - Go to DONE.
- DONE: winner's ack=1; mem_wr=0; go to IDLE.
  - req values in DONE are ignored.
  - A requester that keeps req high after seeing ack is treated as issuing a new request in IDLE.
- The loser's request stays pending and is guaranteed the next grant (no starvation).
- Stores leave rdata unchanged. err is 0 on every legal access.
- mem_addr and mem_din hold their last values in IDLE and DONE.

## Timing
- Outputs are registered. ack and rdata are never combinational from req.
- Latency: req sampled high at posedge T (in IDLE) → ACCESS during cycle T+1 → ack high during cycle T+2.
  - Uncontended latency: 2 cycles.
  - Peak throughput: one access per 3 cycles.
- Worst-case latency for a contended requester: 5 cycles.
- Reset (async, any state):
  - State → IDLE.
  - mem_wr, ack0, ack1, err0, err1 → 0.
  - mem_addr, mem_din, rdata0, rdata1 → 0.
  - Round-robin pointer → initial value.
- Reset asserted during ACCESS: mem_wr drops immediately, the store may be lost, and no ack is issued.
- Reset asserted during DONE: the ack pulse is truncated.

## Configuration
- DM_ARB_ALIGN_CHECK_EN defined:
  - In IDLE, a winning request with addr[1:0] != 0 skips ACCESS. mem_wr stays 0 and the memory is untouched.
  - The FSM goes directly to DONE with ack=1 and err=1; rdata is unchanged.
  - Latency for this case is 1 cycle.
  - Round-robin still counts it as a grant.
- DM_ARB_ALIGN_CHECK_EN not defined:
  - err0 and err1 are tied to 0.
  - Misaligned addresses pass through unchanged, including the 10-bit byte-index wrap for addr[9:0] > 1020.

## Test plan
- Reset then single store/load:
  - Port 0 stores 0xDEADBEEF at 0x10 → ack0 on cycle T+2.
  - Port 0 then loads 0x10 → rdata0=0xDEADBEEF with ack0, err0=0.
- Byte order: port 1 stores 0x11223344 at 0x20; port 0 loads 0x20 → rdata0=0x11223344; ack1 never pulses during the load.
- Simultaneous requests:
  - req0=req1=1 from reset with RR_INIT=0 → grant order 0,1,0,1 over four back-to-back accesses.
  - Each ack is separated by 3 cycles.
  - A load on port 1 started 3 cycles after a store to the same address returns the stored data.
- Held req: req0 stays high for 9 cycles with req1=0 → exactly 3 ack0 pulses, 3 cycles apart.
- Misaligned load of 0x13:
  - With DM_ARB_ALIGN_CHECK_EN: ack0 and err0 at T+1, mem_wr never high, rdata0 unchanged.
  - Without the macro: normal 2-cycle access, err0=0.
- Async reset mid-store (rst low during ACCESS):
  - mem_wr goes to 0 without waiting for clk, and no ack is issued.
  - After release, all outputs are 0 and RR_INIT is favoured on the next simultaneous request.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter and access sequencer for the 1 KiB word data memory.
// Optional build macro DM_ARB_ALIGN_CHECK_EN rejects misaligned word accesses with err.
module dm_arbiter #(
   parameter bit RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_wr,
   input  logic [31:0] mem_dout
);

   // state  | meaning
   // IDLE   | no access in flight; arbitrate and launch on any req
   // ACCESS | memory cycle: store commits / load data captured at its closing edge
   // DONE   | ack (and err) pulse to the winner; reqs ignored
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        win_q, win_d;
   logic        last_q, last_d;
   logic        mem_wr_q, mem_wr_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_din_q, mem_din_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   logic        any_req;
   logic        win;
   logic        win_we;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;
   logic        misalign;

   assign any_req   = req0 | req1;
   // On contention the port that did not win last time gets the grant.
   assign win       = (req0 & req1) ? ~last_q : req1;
   assign win_we    = win ? we1 : we0;
   assign win_addr  = win ? addr1 : addr0;
   assign win_wdata = win ? wdata1 : wdata0;

`ifdef DM_ARB_ALIGN_CHECK_EN
   logic err0_q, err0_d;
   logic err1_q, err1_d;
   assign misalign = |win_addr[1:0];
   assign err0     = err0_q;
   assign err1     = err1_q;
`else
   assign misalign = 1'b0;
   assign err0     = 1'b0;
   assign err1     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = misalign ? DONE : ACCESS;
         ACCESS:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_wr_d   = 1'b0;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      win_d      = win_q;
      last_d     = last_q;
`ifdef DM_ARB_ALIGN_CHECK_EN
      err0_d     = 1'b0;
      err1_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               win_d  = win;
               last_d = win;
               if (misalign) begin
                  ack0_d = ~win;
                  ack1_d = win;
`ifdef DM_ARB_ALIGN_CHECK_EN
                  err0_d = ~win;
                  err1_d = win;
`endif
               end else begin
                  mem_addr_d = win_addr;
                  mem_din_d  = win_wdata;
                  mem_wr_d   = win_we;
               end
            end
         end
         ACCESS: begin
            ack0_d = ~win_q;
            ack1_d = win_q;
            // mem_dout was refreshed at the mid-cycle negedge of this ACCESS cycle.
            if (!mem_wr_q) begin
               if (win_q) rdata1_d = mem_dout;
               else       rdata0_d = mem_dout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q      <= 1'b0;
         last_q     <= ~RR_INIT;
         mem_wr_q   <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
`ifdef DM_ARB_ALIGN_CHECK_EN
         err0_q     <= 1'b0;
         err1_q     <= 1'b0;
`endif
      end else begin
         win_q      <= win_d;
         last_q     <= last_d;
         mem_wr_q   <= mem_wr_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
`ifdef DM_ARB_ALIGN_CHECK_EN
         err0_q     <= err0_d;
         err1_q     <= err1_d;
`endif
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized checks of dm_arbiter against a transaction-level model
// (grant rule, fixed latencies, byte-array memory) with a big-endian negedge-read memory attached.
module tb_dm_arbiter;
   localparam bit RR_INIT = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req [2];
   logic        we [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        ack0, ack1, err0, err1, mem_wr;
   logic [31:0] rdata0, rdata1, mem_addr, mem_din;
   logic [31:0] mem_dout = 32'h0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.RR_INIT(RR_INIT)) dut (
      .clk(clk), .rst(rst),
      .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
      .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_dout(mem_dout)
   );

   // Attached data memory: big-endian bytes, 10-bit byte index wraps.
   logic [7:0] dev [1024] = '{default: 8'h00};
   always @(negedge clk)
      if (!mem_wr)
         mem_dout <= {dev[mem_addr[9:0]], dev[10'(mem_addr[9:0] + 10'd1)],
                      dev[10'(mem_addr[9:0] + 10'd2)], dev[10'(mem_addr[9:0] + 10'd3)]};
   always @(posedge clk)
      if (mem_wr) begin
         dev[mem_addr[9:0]]                <= mem_din[31:24];
         dev[10'(mem_addr[9:0] + 10'd1)]   <= mem_din[23:16];
         dev[10'(mem_addr[9:0] + 10'd2)]   <= mem_din[15:8];
         dev[10'(mem_addr[9:0] + 10'd3)]   <= mem_din[7:0];
      end

   // Reference model
   logic [7:0]  refm [1024] = '{default: 8'h00};
   bit          last_grant;
   int          cyc, free_edge;
   int          ack_edge [2];
   bit          err_at [2], load_at [2], exp_ack [2], exp_err [2];
   logic [31:0] pend_rd [2], exp_rd [2];

   function automatic logic [31:0] ref_rd(input logic [9:0] a);
      return {refm[a], refm[10'(a + 10'd1)], refm[10'(a + 10'd2)], refm[10'(a + 10'd3)]};
   endfunction

   task automatic ref_wr(input logic [9:0] a, input logic [31:0] d);
      refm[a] = d[31:24]; refm[10'(a + 10'd1)] = d[23:16];
      refm[10'(a + 10'd2)] = d[15:8]; refm[10'(a + 10'd3)] = d[7:0];
   endtask

   task automatic model_reset();
      cyc = 0; free_edge = 0; last_grant = !RR_INIT;
      for (int p = 0; p < 2; p++) begin
         ack_edge[p] = -10; err_at[p] = 0; load_at[p] = 0;
         exp_ack[p] = 0; exp_err[p] = 0; exp_rd[p] = 32'h0; pend_rd[p] = 32'h0;
      end
   endtask

   // One clock: model decides a grant from the reqs seen at this edge, then outputs settle.
   task automatic tick();
      int w;
      bit mis;
      cyc++;
      if (cyc >= free_edge && (req[0] || req[1])) begin
         w = (req[0] && req[1]) ? (last_grant ? 0 : 1) : (req[1] ? 1 : 0);
         last_grant = (w == 1);
         mis = 1'b0;
`ifdef DM_ARB_ALIGN_CHECK_EN
         mis = (addr[w][1:0] != 2'b00);
`endif
         if (mis) begin
            ack_edge[w] = cyc; err_at[w] = 1; load_at[w] = 0; free_edge = cyc + 2;
         end else begin
            ack_edge[w] = cyc + 1; err_at[w] = 0; load_at[w] = !we[w];
            pend_rd[w] = we[w] ? 32'h0 : ref_rd(addr[w][9:0]);
            if (we[w]) ref_wr(addr[w][9:0], wdata[w]);
            free_edge = cyc + 3;
         end
      end
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
         exp_ack[p] = (ack_edge[p] == cyc);
         exp_err[p] = exp_ack[p] && err_at[p];
         if (exp_ack[p] && load_at[p]) exp_rd[p] = pend_rd[p];
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({ack0, ack1, err0, err1, mem_wr} !== 5'b0) begin failures++;
         $display("FAIL reset_ctl: ack0 ack1 err0 err1 mem_wr=%b expected 00000", {ack0, ack1, err0, err1, mem_wr}); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: %h expected 0", mem_addr); end
      checks++; if (mem_din !== 32'h0) begin failures++; $display("FAIL reset_din: %h expected 0", mem_din); end
      checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin failures++;
         $display("FAIL reset_rdata: %h %h expected 0 0", rdata0, rdata1); end
   endtask

   task automatic test_single();
      req[0] = 1; we[0] = 1; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
      tick();
      checks++; if (ack0 !== 1'b0 || mem_wr !== 1'b1) begin failures++;
         $display("FAIL st_access: ack0=%b mem_wr=%b expected 0 1", ack0, mem_wr); end
      checks++; if (mem_addr[9:0] !== 10'h010 || mem_din !== 32'hDEADBEEF) begin failures++;
         $display("FAIL st_bus: addr=%h din=%h expected 010 DEADBEEF", mem_addr[9:0], mem_din); end
      tick();
      checks++; if (ack0 !== 1'b1 || mem_wr !== 1'b0) begin failures++;
         $display("FAIL st_ack: ack0=%b mem_wr=%b expected 1 0", ack0, mem_wr); end
      req[0] = 0;
      tick();
      checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL st_pulse: ack0=%b expected 0", ack0); end
      req[0] = 1; we[0] = 0;
      tick(); tick();
      checks++; if (ack0 !== 1'b1 || err0 !== 1'b0) begin failures++;
         $display("FAIL ld_ack: ack0=%b err0=%b expected 1 0", ack0, err0); end
      checks++; if (rdata0 !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_data: %h expected DEADBEEF", rdata0); end
      req[0] = 0;
      tick();
   endtask

   task automatic test_byte_order();
      bit got, seen1;
      req[1] = 1; we[1] = 1; addr[1] = 32'h20; wdata[1] = 32'h11223344;
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin tick(); got = ack1; end
      checks++; if (!got) begin failures++; $display("FAIL bo_store: no ack1 within 6 cycles, expected one"); end
      req[1] = 0;
      tick();
      checks++; if ({dev[32], dev[33], dev[34], dev[35]} !== 32'h11223344) begin failures++;
         $display("FAIL bo_bytes: %h expected 11223344", {dev[32], dev[33], dev[34], dev[35]}); end
      req[0] = 1; we[0] = 0; addr[0] = 32'h20;
      got = 0; seen1 = 0;
      for (int i = 0; i < 6 && !got; i++) begin tick(); if (ack1) seen1 = 1; got = ack0; end
      checks++; if (!got || rdata0 !== 32'h11223344) begin failures++;
         $display("FAIL bo_load: ack=%b rdata0=%h expected 1 11223344", got, rdata0); end
      checks++; if (seen1) begin failures++; $display("FAIL bo_ack1: ack1 pulsed=1 expected 0"); end
      req[0] = 0;
      tick();
   endtask

   task automatic test_contention();
      int n;
      int port [4];
      int when [4];
      do_reset();
      req[0] = 1; we[0] = 1; addr[0] = 32'h40; wdata[0] = 32'hCAFE0001;
      req[1] = 1; we[1] = 0; addr[1] = 32'h40;
      n = 0;
      for (int k = 0; k < 4; k++) begin port[k] = -1; when[k] = -1; end
      for (int i = 1; i <= 14 && n < 4; i++) begin
         tick();
         checks++; if ({ack1, ack0} !== {exp_ack[1], exp_ack[0]}) begin failures++;
            $display("FAIL rr_ack: ack1,ack0=%b%b expected %b%b", ack1, ack0, exp_ack[1], exp_ack[0]); end
         if (ack0 || ack1) begin port[n] = ack1 ? 1 : 0; when[n] = i; n++; end
      end
      req[0] = 0; req[1] = 0;
      tick();
      for (int k = 0; k < 4; k++) begin
         checks++; if (port[k] != (k % 2 == 0 ? int'(RR_INIT) : int'(!RR_INIT))) begin failures++;
            $display("FAIL rr_order: grant %0d went to port %0d expected %0d", k, port[k], (k % 2 == 0) ? int'(RR_INIT) : int'(!RR_INIT)); end
      end
      for (int k = 1; k < 4; k++) begin
         checks++; if (when[k] - when[k-1] != 3) begin failures++;
            $display("FAIL rr_gap: ack spacing %0d expected 3", when[k] - when[k-1]); end
      end
      checks++; if (rdata1 !== 32'hCAFE0001) begin failures++; $display("FAIL rr_data: rdata1=%h expected CAFE0001", rdata1); end
   endtask

   task automatic test_held_req();
      int cnt;
      int t [3];
      req[0] = 1; we[0] = 0; addr[0] = 32'h40;
      cnt = 0;
      for (int k = 0; k < 3; k++) t[k] = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (ack0) begin if (cnt < 3) t[cnt] = i; cnt++; end
         if (i == 9) req[0] = 0;
      end
      checks++; if (cnt != 3) begin failures++; $display("FAIL held_count: %0d acks expected 3", cnt); end
      checks++; if (t[1] - t[0] != 3 || t[2] - t[1] != 3) begin failures++;
         $display("FAIL held_gap: acks at %0d %0d %0d expected 3 apart", t[0], t[1], t[2]); end
      checks++; if (rdata0 !== 32'hCAFE0001) begin failures++; $display("FAIL held_data: %h expected CAFE0001", rdata0); end
   endtask

   task automatic test_misaligned();
      bit got, wr_seen;
      req[0] = 1; we[0] = 1; addr[0] = 32'h14; wdata[0] = 32'h55667788;
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin tick(); got = ack0; end
      req[0] = 0;
      tick();
      checks++; if (!got) begin failures++; $display("FAIL mis_setup: no ack0 within 6 cycles, expected one"); end
      req[0] = 1; we[0] = 0; addr[0] = 32'h13;
      wr_seen = 0;
      tick(); if (mem_wr) wr_seen = 1;
`ifdef DM_ARB_ALIGN_CHECK_EN
      checks++; if (ack0 !== 1'b1 || err0 !== 1'b1) begin failures++;
         $display("FAIL mis_err: ack0=%b err0=%b expected 1 1", ack0, err0); end
      checks++; if (rdata0 !== 32'hCAFE0001) begin failures++; $display("FAIL mis_rdata: %h expected CAFE0001", rdata0); end
      req[0] = 0;
      tick(); if (mem_wr) wr_seen = 1;
      tick(); if (mem_wr) wr_seen = 1;
      checks++; if (wr_seen) begin failures++; $display("FAIL mis_memwr: mem_wr seen=1 expected 0"); end
`else
      checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL mis_early: ack0=%b expected 0", ack0); end
      tick(); if (mem_wr) wr_seen = 1;
      checks++; if (ack0 !== 1'b1 || err0 !== 1'b0) begin failures++;
         $display("FAIL mis_ack: ack0=%b err0=%b expected 1 0", ack0, err0); end
      checks++; if (rdata0 !== 32'hEF556677 || wr_seen) begin failures++;
         $display("FAIL mis_data: rdata0=%h mem_wr_seen=%b expected EF556677 0", rdata0, wr_seen); end
      req[0] = 0;
      tick();
`endif
   endtask

   task automatic new_txn(input int p);
      logic [31:0] a;
      a = $urandom;
      a[9:0] = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 63)) : 10'($urandom_range(960, 1023));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      addr[p] = a; we[p] = ($urandom_range(0, 1) == 1); wdata[p] = $urandom; req[p] = 1;
   endtask

   task automatic test_random();
      req[0] = 0; req[1] = 0;
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) if (!req[p] && $urandom_range(0, 2) == 0) new_txn(p);
         tick();
         checks++; if (ack0 !== exp_ack[0] || err0 !== exp_err[0]) begin failures++;
            $display("FAIL rnd_p0_ack: cyc %0d ack0=%b err0=%b expected %b %b", cyc, ack0, err0, exp_ack[0], exp_err[0]); end
         checks++; if (ack1 !== exp_ack[1] || err1 !== exp_err[1]) begin failures++;
            $display("FAIL rnd_p1_ack: cyc %0d ack1=%b err1=%b expected %b %b", cyc, ack1, err1, exp_ack[1], exp_err[1]); end
         checks++; if (rdata0 !== exp_rd[0]) begin failures++;
            $display("FAIL rnd_rdata0: cyc %0d %h expected %h", cyc, rdata0, exp_rd[0]); end
         checks++; if (rdata1 !== exp_rd[1]) begin failures++;
            $display("FAIL rnd_rdata1: cyc %0d %h expected %h", cyc, rdata1, exp_rd[1]); end
         for (int p = 0; p < 2; p++)
            if (exp_ack[p]) begin
               if ($urandom_range(0, 2) == 0) new_txn(p);
               else req[p] = 0;
            end
      end
      req[0] = 0; req[1] = 0;
      repeat (3) tick();
   endtask

   task automatic test_async_reset();
      bit got;
      req[0] = 1; we[0] = 1; addr[0] = 32'h80; wdata[0] = 32'h99999999;
      tick();
      checks++; if (mem_wr !== 1'b1) begin failures++; $display("FAIL ar_access: mem_wr=%b expected 1", mem_wr); end
      #2 rst = 1'b0;
      #1;
      checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL ar_memwr: mem_wr=%b expected 0 without clock", mem_wr); end
      req[0] = 0;
      @(posedge clk); #1;
      checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL ar_noack: ack0=%b expected 0", ack0); end
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      checks++; if ({ack0, ack1, err0, err1, mem_wr} !== 5'b0 || mem_addr !== 32'h0 || mem_din !== 32'h0
                    || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin failures++;
         $display("FAIL ar_outputs: ctl=%b addr=%h din=%h rd0=%h rd1=%h expected all 0",
                  {ack0, ack1, err0, err1, mem_wr}, mem_addr, mem_din, rdata0, rdata1); end
      req[0] = 1; we[0] = 0; addr[0] = 32'h10;
      req[1] = 1; we[1] = 0; addr[1] = 32'h20;
      got = 0;
      for (int i = 0; i < 4 && !got; i++) begin tick(); got = ack0 | ack1; end
      checks++; if ({ack1, ack0} !== (RR_INIT ? 2'b10 : 2'b01)) begin failures++;
         $display("FAIL ar_rrinit: ack1,ack0=%b%b expected %b", ack1, ack0, (RR_INIT ? 2'b10 : 2'b01)); end
      checks++; if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin failures++;
         $display("FAIL ar_rdata: %h %h expected %h %h", rdata0, rdata1, exp_rd[0], exp_rd[1]); end
      req[0] = 0; req[1] = 0;
      repeat (3) tick();
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin req[p] = 0; we[p] = 0; addr[p] = 32'h0; wdata[p] = 32'h0; end
      model_reset();
      test_reset();
      test_single();
      test_byte_order();
      test_contention();
      test_held_req();
      test_misaligned();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
